// File: rtl/conv2_relu_pool_if.sv
// Stream interface between the conv2 channel calculator, the post-processing stage and the
// next layer's line buffer.
interface conv2_relu_pool_if #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 12
);
    logic                    valid_in;
    logic signed [IN_W-1:0]  data_in;
    logic        [OUT_W-1:0] data_out;
    logic                    valid_out;
    logic                    frame_done;

    modport master (
        output valid_in,
        output data_in,
        input  data_out,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output data_out,
        output valid_out,
        output frame_done
    );
endinterface

// File: rtl/conv2_relu_pool.sv
// Bias + ReLU + requantize to OUT_W bits, then 2x2 stride-2 max pooling over a raster stream.
// One input per cycle, no backpressure, two cycles from window-completing input to output.
module conv2_relu_pool #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 12,
    parameter int MAP_W = 8,
    parameter int MAP_H = 8,
    parameter int BIAS  = 0,
    parameter int SHIFT = 2
) (
    input logic              clk,
    input logic              rst,
    conv2_relu_pool_if.slave bus
);
    localparam int ColW = $clog2(MAP_W);
    localparam int RowW = $clog2(MAP_H);
    localparam int Half = MAP_W / 2;

    localparam logic [IN_W-1:0] BiasV  = IN_W'(BIAS);
    localparam logic [IN_W:0]   ActMax = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(MAP_W - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(MAP_H - 1);

    logic [IN_W:0]      sum;
    logic [IN_W:0]      relu;
    logic [IN_W:0]      quant;
    logic [OUT_W-1:0]   act_d;

    logic               v1_q;
    logic [OUT_W-1:0]   act_q;
    logic [ColW-1:0]    col_q;
    logic [RowW-1:0]    row_q;
    logic [OUT_W-1:0]   hold_q;
    logic [OUT_W-1:0]   line_buf_q [Half];
    logic [OUT_W-1:0]   data_out_q;
    logic               valid_out_q;
    logic               frame_done_q;

    logic [OUT_W-1:0]   hmax;
    logic [OUT_W-1:0]   lb_rd;
    logic [OUT_W-1:0]   pooled;
    logic               col_last;
    logic               row_last;

    // Sum is one bit wider than the input so bias can never wrap a negative into a positive.
    always_comb begin
        sum   = {bus.data_in[IN_W-1], bus.data_in} + {BiasV[IN_W-1], BiasV};
        relu  = sum[IN_W] ? '0 : sum;
        quant = relu >> SHIFT;
        act_d = (quant > ActMax) ? ActMax[OUT_W-1:0] : quant[OUT_W-1:0];
    end

    always_comb begin
        col_last = (col_q == ColLast);
        row_last = (row_q == RowLast);
        hmax     = (hold_q > act_q) ? hold_q : act_q;
        lb_rd    = line_buf_q[col_q[ColW-1:1]];
        pooled   = (lb_rd > hmax) ? lb_rd : hmax;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q         <= 1'b0;
            act_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < Half; i++) begin
                line_buf_q[i] <= '0;
            end
        end else begin
            v1_q         <= bus.valid_in;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.valid_in) begin
                act_q <= act_d;
            end
            if (v1_q) begin
                col_q <= col_last ? '0 : col_q + 1'b1;
                if (col_last) begin
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end
                // Even rows park the horizontal max; odd rows combine it with the parked one.
                if (!col_q[0]) begin
                    hold_q <= act_q;
                end else if (!row_q[0]) begin
                    line_buf_q[col_q[ColW-1:1]] <= hmax;
                end else begin
                    data_out_q   <= pooled;
                    valid_out_q  <= 1'b1;
                    frame_done_q <= col_last && row_last;
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/conv2_relu_pool.md
Name: conv2_relu_pool

Overview:
- Post-processing stage directly downstream of a conv2 per-channel calculator.
- Consumes the 14-bit signed convolution sum stream for one output channel, one sample per valid cycle, in raster order.
- Applies bias add, ReLU, requantization to 12-bit activations, then 2x2 stride-2 max pooling.
- Emits the pooled feature map, 4x4 for an 8x8 input, to the next layer's line buffer.

Parameters:
- IN_W, 14, input sample width (signed).
- OUT_W, 12, output activation width (signed, always non-negative after ReLU).
- MAP_W, 8, input feature map width; must be even.
- MAP_H, 8, input feature map height; must be even.
- BIAS, 0, signed IN_W-bit bias added to every sample.
- SHIFT, 2, arithmetic right shift applied after ReLU.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  data_in is a valid sample this cycle; one sample per high cycle; gaps allowed.
- data_in  input  IN_W  signed convolution sum.
- data_out  output  OUT_W  pooled activation.
- valid_out  output  1  single-cycle strobe; data_out is valid.
- frame_done  output  1  single-cycle strobe coincident with the last pooled output of a frame.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst is high:
  - all outputs are 0: data_out, valid_out, frame_done;
  - counters, holding register, stage-1 register and line-buffer contents are cleared.
- Reset asserted mid-frame discards the partial frame. The first valid_in after release is pixel (0,0).
- Stage 1, registered, 1 cycle:
  - sum = sign-extend(data_in) + sign-extend(BIAS), computed at IN_W+1 bits with no overflow.
  - relu = (sum < 0) ? 0 : sum.
  - q = relu >>> SHIFT.
  - act = min(q, 2^(OUT_W-1)-1), i.e. saturates at 2047.
  - The stage-1 valid bit (v1) follows valid_in one cycle later.
- Position counters col (0..MAP_W-1) and row (0..MAP_H-1) advance only on v1.
  - col wraps to 0 at MAP_W-1 and increments row.
  - row wraps to 0 at MAP_H-1 (frame end).
  - No idle state is needed; the next frame starts immediately.
- Pooling, evaluated on v1 using the current (col,row):
  - col even: hold_reg <= act.
  - col odd: hmax = max(hold_reg, act), unsigned compare (values are non-negative).
  - col odd, row even: line_buf[col>>1] <= hmax. line_buf has MAP_W/2 entries of OUT_W bits.
  - col odd, row odd: data_out <= max(line_buf[col>>1], hmax); valid_out <= 1.
  - Otherwise valid_out <= 0.
  - data_out holds its last value when valid_out is low.
- frame_done <= 1 in the same cycle valid_out is set for (col,row) = (MAP_W-1, MAP_H-1); otherwise 0.
- Latency: valid_in high for the bottom-right pixel of a 2x2 window in cycle t gives valid_out high in cycle t+2.
- Throughput: one input per cycle sustained. No backpressure; the downstream stage must accept every valid_out.
- Gaps in valid_in freeze counters, hold_reg and line_buf. Window state survives any gap length.
- Line-buffer read and write of the same entry never occur in the same cycle; even and odd rows are disjoint.
- Pooled outputs per frame: (MAP_W/2)*(MAP_H/2), 16 at defaults, in raster order of the pooled map.

Test Plan:
- ReLU and bias:
  - BIAS=0, SHIFT=2, 8x8 frame all data_in=-100 -> 16 valid_out, each data_out=0; frame_done on the 16th.
  - BIAS=-20, all data_in=40 -> every output = (40-20)>>2 = 5.
- Saturation: BIAS=100, SHIFT=2, all data_in=8191 -> sum 8291 >> 2 = 2072, clamped; every data_out=2047. Also data_in=-8192 with BIAS=-8192 -> 0, with no wrap to positive.
- Pooling ramp: BIAS=0, SHIFT=2, data_in=4*(r*8+c), back-to-back valid_in ->
  - outputs 9,11,13,15,25,...,63;
  - first valid_out exactly 2 cycles after the input for pixel (1,1);
  - frame_done only with 63.
- Gapped input: same ramp with valid_in low for a random 0-5 cycles between samples -> identical output sequence and count; valid_out never repeats during gaps.
- Mid-frame reset and back-to-back frames:
  - Assert rst after 37 samples -> outputs immediately 0.
  - Then two ramp frames back to back -> exactly 32 outputs, each frame 9..63, with 2 frame_done strobes.
